// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the round-robin fifo write arbiter.
// Holds the FSM encoding and a small index helper.
package fifo_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshakes plus fifo write port.
// slave = arbiter side, master = producers/fifo side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic [IW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_data_in,
    input  grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_data_in,
    output grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Rotating priority pick: first valid index
// scanning from rr_ptr upward, modulo NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  // Descending scan so the smallest offset wins.
  always_comb begin
    int j;
    j = 0;
    found_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (req_valid_i[j]) begin
        found_o = 1'b1;
        idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port;
// each grant allows up to MAX_BURST writes.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 2
) (
  input logic          clk,
  input logic          rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [BW-1:0] burst_cnt_q;

  logic          found;
  logic [IW-1:0] pick_idx;

  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_valid_i(bus.req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .found_o    (found),
    .idx_o      (pick_idx)
  );

  logic                  grant;
  logic                  own_valid;
  logic                  xfer;
  logic                  last;
  logic [DATA_WIDTH-1:0] own_data;
  logic [NUM_REQ-1:0]    ready;

  assign grant = (state_q == ARB_GRANT);
  assign own_valid = bus.req_valid[owner_q];
  assign xfer = grant & own_valid & ~bus.fifo_full;
  assign last = (burst_cnt_q == BW'(MAX_BURST - 1));

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant) begin
      ready[owner_q] = ~bus.fifo_full;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fifo_wr = xfer;
  assign bus.fifo_data_in = xfer ? own_data : '0;
  assign bus.grant_id = grant ? owner_q : '0;
  assign bus.busy = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            owner_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer) begin
            burst_cnt_q <= burst_cnt_q + BW'(1);
          end
          // A full fifo with valid held just stalls here.
          if ((xfer && last) || !own_valid) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= IW'(wrap_inc(int'(owner_q), NUM_REQ));
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: producer queues and a depth-4 fifo
// model around the arbiter, immediate-assert checks.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(4)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(4),
    .MAX_BURST(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int ntests = 0;
  int nfail = 0;

  logic [3:0] pq[4][$];
  logic [3:0] fq[$];
  logic [3:0] rdlog[$];
  logic [1:0] glog[$];
  logic       prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = (pq[i].size() != 0);
      bus.req_data[i*4 +: 4] = (pq[i].size() != 0) ? pq[i][0] : 4'h0;
    end
    bus.fifo_full = (fq.size() >= 4);
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic cyc(input bit rd);
    logic [3:0] hs;
    logic       wr;
    logic [3:0] din;
    #1;
    hs = bus.req_valid & bus.req_ready;
    wr = bus.fifo_wr;
    din = bus.fifo_data_in;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) void'(pq[i].pop_front());
    end
    if (rd && fq.size() != 0) rdlog.push_back(fq.pop_front());
    if (wr) fq.push_back(din);
    @(negedge clk);
    settle();
    if (bus.busy && !prev_busy) glog.push_back(bus.grant_id);
    prev_busy = bus.busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pq[i].delete();
    fq.delete();
    rdlog.delete();
    glog.delete();
    prev_busy = 1'b0;
    settle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    settle();
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_wr"}, 32'(bus.fifo_wr), 32'h0);
    chk({tag, "_din"}, 32'(bus.fifo_data_in), 32'h0);
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  logic [3:0] gold[$];

  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;

    // 1: async reset with everyone valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back(4'(i + 1));
      pq[i].push_back(4'(i + 5));
    end
    settle();
    cyc(0);
    chk("t1_pre_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_pre_wr", 32'(bus.fifo_wr), 32'h1);
    rst = 1'b0;
    #1;
    chk_idle_outs("t1_rst");
    @(negedge clk);
    rst = 1'b1;
    settle();
    cyc(0);
    chk("t1_gid", 32'(bus.grant_id), 32'h0);
    chk("t1_busy", 32'(bus.busy), 32'h1);

    // 2: single requester, burst split by idle bubble
    do_reset();
    pq[2].push_back(4'hA);
    pq[2].push_back(4'hB);
    pq[2].push_back(4'hC);
    settle();
    chk_idle_outs("t2_c0");
    cyc(0);
    chk("t2_c1_gid", 32'(bus.grant_id), 32'h2);
    chk("t2_c1_ready", 32'(bus.req_ready), 32'h4);
    chk("t2_c1_din", 32'(bus.fifo_data_in), 32'hA);
    cyc(0);
    chk("t2_c2_din", 32'(bus.fifo_data_in), 32'hB);
    cyc(0);
    chk("t2_c3_busy", 32'(bus.busy), 32'h0);
    chk("t2_c3_wr", 32'(bus.fifo_wr), 32'h0);
    cyc(0);
    chk("t2_c4_gid", 32'(bus.grant_id), 32'h2);
    chk("t2_c4_din", 32'(bus.fifo_data_in), 32'hC);
    cyc(0);
    chk("t2_c5_wr", 32'(bus.fifo_wr), 32'h0);
    chk("t2_c5_busy", 32'(bus.busy), 32'h1);
    cyc(0);
    chk("t2_c6_busy", 32'(bus.busy), 32'h0);
    chk("t2_fsize", 32'(fq.size()), 32'd3);
    gold = '{4'hA, 4'hB, 4'hC};
    for (int i = 0; i < 3; i++) begin
      if (i < fq.size()) chk("t2_fifo", 32'(fq[i]), 32'(gold[i]));
    end

    // 3: all valid, reads every cycle
    do_reset();
    pq[0] = '{4'h1, 4'h2, 4'h9, 4'hA};
    pq[1] = '{4'h3, 4'h4};
    pq[2] = '{4'h5, 4'h6};
    pq[3] = '{4'h7, 4'h8};
    settle();
    repeat (20) cyc(1);
    gold = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
             4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    chk("t3_nread", 32'(rdlog.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < rdlog.size()) chk("t3_rd", 32'(rdlog[i]), 32'(gold[i]));
    end
    chk("t3_ngrant", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) chk("t3_gorder", 32'(glog[i]), 32'(i % 4));
    end

    // 4: full stall, one read releases one word
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back(4'(2 * i + 1));
      pq[i].push_back(4'(2 * i + 2));
    end
    settle();
    repeat (7) cyc(0);
    chk("t4_full", 32'(bus.fifo_full), 32'h1);
    chk("t4_gid", 32'(bus.grant_id), 32'h2);
    chk("t4_ready", 32'(bus.req_ready), 32'h0);
    chk("t4_wr", 32'(bus.fifo_wr), 32'h0);
    cyc(0);
    chk("t4_hold_busy", 32'(bus.busy), 32'h1);
    chk("t4_hold_wr", 32'(bus.fifo_wr), 32'h0);
    chk("t4_fsize", 32'(fq.size()), 32'd4);
    cyc(1);
    chk("t4_rd_ready", 32'(bus.req_ready), 32'h4);
    chk("t4_rd_wr", 32'(bus.fifo_wr), 32'h1);
    chk("t4_rd_din", 32'(bus.fifo_data_in), 32'h5);
    cyc(0);
    gold = '{4'h2, 4'h3, 4'h4, 4'h5};
    chk("t4_fsize2", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < fq.size()) chk("t4_fifo", 32'(fq[i]), 32'(gold[i]));
    end

    // 5: early drop rotates past waiting req0
    do_reset();
    pq[1].push_back(4'hD);
    settle();
    cyc(0);
    chk("t5_gid1", 32'(bus.grant_id), 32'h1);
    chk("t5_din", 32'(bus.fifo_data_in), 32'hD);
    cyc(0);
    pq[0].push_back(4'hE);
    pq[2].push_back(4'hF);
    settle();
    chk("t5_drop_wr", 32'(bus.fifo_wr), 32'h0);
    chk("t5_drop_ready", 32'(bus.req_ready), 32'h2);
    cyc(0);
    chk("t5_idle", 32'(bus.busy), 32'h0);
    cyc(0);
    chk("t5_gid2", 32'(bus.grant_id), 32'h2);
    chk("t5_din2", 32'(bus.fifo_data_in), 32'hF);
    chk("t5_fsize", 32'(fq.size()), 32'd1);

    // 6: reset in the middle of req3's burst
    do_reset();
    pq[3].push_back(4'h1);
    pq[3].push_back(4'h2);
    settle();
    cyc(0);
    chk("t6_gid3", 32'(bus.grant_id), 32'h3);
    cyc(0);
    chk("t6_din2", 32'(bus.fifo_data_in), 32'h2);
    rst = 1'b0;
    #1;
    chk_idle_outs("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    pq[0].push_back(4'h3);
    settle();
    chk("t6_fsize", 32'(fq.size()), 32'd1);
    if (fq.size() != 0) chk("t6_fifo0", 32'(fq[0]), 32'h1);
    cyc(0);
    chk("t6_gid0", 32'(bus.grant_id), 32'h0);
    chk("t6_din3", 32'(bus.fifo_data_in), 32'h3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
